// File: rtl/gnrc_frac_pkg.sv
// Shared types and config validity check for the fractional counter bank.
//   mode_e       : channel mode (WRAP / ONESHOT; 2 and 3 reserved)
//   chan_state_e : per-channel state (IDLE / RUN / DONE)
//   frac_cfg_ok  : 1 when a {max, inc, mode} triple is legal
package gnrc_frac_pkg;

   // Counter widths up to this value are supported by frac_cfg_ok.
   localparam int unsigned FRAC_CFG_W = 64;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_ONESHOT = 2'd1
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chan_state_e;

   // Legal config: non-zero modulus, increment strictly below it, known mode.
   function automatic logic frac_cfg_ok(input logic [FRAC_CFG_W-1:0] max_v,
                                        input logic [FRAC_CFG_W-1:0] inc_v,
                                        input logic [1:0]            mode_v);
      return (max_v != '0) && (inc_v < max_v) && (mode_v <= 2'd1);
   endfunction

endpackage

// File: rtl/gnrc_frac_chan.sv
// One fractional counter channel: FSM, shadow config slot and modulo arithmetic.
//   clk_i, arst_i         : clock, async active-high reset
//   en_i, clr_i, down_i   : step enable, sync clear, direction (1 = subtract)
//   cfg_we_i              : validated config addressed to this channel
//   cfg_max_i/inc_i/mode_i: config payload; cfg_imm_i selects immediate commit
//   pend_o                : shadow slot occupied
//   cnt_o, ovf_o, done_o  : accumulator, wrap pulse, sticky one-shot done
module gnrc_frac_chan
   import gnrc_frac_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic         clk_i,
   input  logic         arst_i,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic         down_i,
   input  logic         cfg_we_i,
   input  logic [N-1:0] cfg_max_i,
   input  logic [N-1:0] cfg_inc_i,
   input  mode_e        cfg_mode_i,
   input  logic         cfg_imm_i,
   output logic         pend_o,
   output logic [N-1:0] cnt_o,
   output logic         ovf_o,
   output logic         done_o
);

   chan_state_e  state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic         ovf_q, ovf_d;
   logic         done_q, done_d;
   logic [N-1:0] max_q, max_d, inc_q, inc_d;
   mode_e        mode_q, mode_d;
   logic         pend_q, pend_d;
   logic [N-1:0] pmax_q, pmax_d, pinc_q, pinc_d;
   mode_e        pmode_q, pmode_d;

   logic [N:0]   up_sum_c, dn_sum_c;
   logic [N-1:0] step_cnt_c;
   logic         wrap_c, step_c, imm_commit_c, def_commit_c;

   // Registers
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         max_q   <= '0;
         inc_q   <= '0;
         mode_q  <= MODE_WRAP;
         pend_q  <= 1'b0;
         pmax_q  <= '0;
         pinc_q  <= '0;
         pmode_q <= MODE_WRAP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         max_q   <= max_d;
         inc_q   <= inc_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         pmax_q  <= pmax_d;
         pinc_q  <= pinc_d;
         pmode_q <= pmode_d;
      end
   end

   // Next state: step with active parameters, then commits, then clear
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = 1'b0;
      max_d   = max_q;
      inc_d   = inc_q;
      mode_d  = mode_q;
      pend_d  = pend_q;
      pmax_d  = pmax_q;
      pinc_d  = pinc_q;
      pmode_d = pmode_q;

      up_sum_c = (N+1)'(cnt_q) + (N+1)'(inc_q);
      dn_sum_c = (N+1)'(cnt_q) + (N+1)'(max_q) - (N+1)'(inc_q);
      if (down_i) begin
         wrap_c     = (cnt_q < inc_q);
         step_cnt_c = wrap_c ? N'(dn_sum_c) : (cnt_q - inc_q);
      end else begin
         wrap_c     = (up_sum_c >= (N+1)'(max_q));
         step_cnt_c = wrap_c ? N'(up_sum_c - (N+1)'(max_q)) : N'(up_sum_c);
      end

      step_c       = (state_q == ST_RUN) && en_i && !clr_i;
      // An idle channel never wraps, so a deferred config to it commits at once.
      imm_commit_c = cfg_we_i && (cfg_imm_i || (state_q == ST_IDLE));
      def_commit_c = pend_q && step_c && wrap_c;

      if (step_c) begin
         cnt_d = step_cnt_c;
         ovf_d = wrap_c;
         if (wrap_c && (mode_q == MODE_ONESHOT)) state_d = ST_DONE;
      end

      if (cfg_we_i && !imm_commit_c) begin
         pend_d  = 1'b1;
         pmax_d  = cfg_max_i;
         pinc_d  = cfg_inc_i;
         pmode_d = cfg_mode_i;
      end

      // Commits take effect after this edge; cnt keeps its value.
      if (imm_commit_c) begin
         max_d   = cfg_max_i;
         inc_d   = cfg_inc_i;
         mode_d  = cfg_mode_i;
         state_d = ST_RUN;
      end else if (def_commit_c) begin
         max_d   = pmax_q;
         inc_d   = pinc_q;
         mode_d  = pmode_q;
         pend_d  = 1'b0;
         state_d = ST_RUN;
      end

      if (clr_i) begin
         cnt_d = '0;
         if (state_q == ST_DONE) state_d = ST_RUN;
      end

      done_d = (state_d == ST_DONE);
   end

   assign pend_o = pend_q;
   assign cnt_o  = cnt_q;
   assign ovf_o  = ovf_q;
   assign done_o = done_q;

endmodule

// File: rtl/gnrc_frac_counter_bank.sv
// Multi-channel fractional counter bank (rate / strobe generator).
//   clk_i, arst_i        : clock, async active-high reset
//   cfg_valid_i/ready_o  : config handshake, cfg_ch_i selects the channel
//   cfg_max_i/inc_i/mode_i/imm_i : config payload
//   cfg_err_o            : one-cycle pulse after an accepted but rejected config
//   en_i, clr_i, down_i  : per-channel step enable, clear, direction
//   cnt_o, ovf_o, done_o : per-channel accumulator, wrap pulse, one-shot done
module gnrc_frac_counter_bank
   import gnrc_frac_pkg::*;
#(
   parameter  int unsigned N  = 16,
   parameter  int unsigned CH = 4,
   localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            cfg_valid_i,
   output logic            cfg_ready_o,
   input  logic [CW-1:0]   cfg_ch_i,
   input  logic [N-1:0]    cfg_max_i,
   input  logic [N-1:0]    cfg_inc_i,
   input  logic [1:0]      cfg_mode_i,
   input  logic            cfg_imm_i,
   output logic            cfg_err_o,
   input  logic [CH-1:0]   en_i,
   input  logic [CH-1:0]   clr_i,
   input  logic [CH-1:0]   down_i,
   output logic [CH*N-1:0] cnt_o,
   output logic [CH-1:0]   ovf_o,
   output logic [CH-1:0]   done_o
);

   logic [CH-1:0] hit_c, pend_c, cfg_we_c;
   logic          cfg_ok_c, accept_c;
   logic          cfg_err_q, cfg_err_d;

   // Channel decode, ready mux and validity; out-of-range channels are rejected.
   always_comb begin
      hit_c       = '0;
      cfg_ready_o = 1'b1;
      for (int unsigned i = 0; i < CH; i++) begin
         hit_c[i] = (cfg_ch_i == CW'(i));
         if (hit_c[i]) cfg_ready_o = !pend_c[i];
      end
      cfg_ok_c  = frac_cfg_ok(FRAC_CFG_W'(cfg_max_i), FRAC_CFG_W'(cfg_inc_i), cfg_mode_i);
      accept_c  = cfg_valid_i && cfg_ready_o;
      cfg_we_c  = hit_c & {CH{accept_c && cfg_ok_c}};
      cfg_err_d = accept_c && (!cfg_ok_c || !(|hit_c));
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) cfg_err_q <= 1'b0;
      else        cfg_err_q <= cfg_err_d;
   end

   assign cfg_err_o = cfg_err_q;

   for (genvar g = 0; g < CH; g++) begin : g_chan
      gnrc_frac_chan #(.N(N)) u_chan (
         .clk_i      (clk_i),
         .arst_i     (arst_i),
         .en_i       (en_i[g]),
         .clr_i      (clr_i[g]),
         .down_i     (down_i[g]),
         .cfg_we_i   (cfg_we_c[g]),
         .cfg_max_i  (cfg_max_i),
         .cfg_inc_i  (cfg_inc_i),
         .cfg_mode_i (mode_e'(cfg_mode_i)),
         .cfg_imm_i  (cfg_imm_i),
         .pend_o     (pend_c[g]),
         .cnt_o      (cnt_o[g*N +: N]),
         .ovf_o      (ovf_o[g]),
         .done_o     (done_o[g])
      );
   end

endmodule

// File: tb/tb_gnrc_frac_counter_bank.sv
// Directed self-checking bench for gnrc_frac_counter_bank (N=16, CH=4).
module tb_gnrc_frac_counter_bank;

   logic        clk_i = 1'b0;
   logic        arst_i;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic [1:0]  cfg_ch_i;
   logic [15:0] cfg_max_i;
   logic [15:0] cfg_inc_i;
   logic [1:0]  cfg_mode_i;
   logic        cfg_imm_i;
   logic        cfg_err_o;
   logic [3:0]  en_i;
   logic [3:0]  clr_i;
   logic [3:0]  down_i;
   logic [63:0] cnt_o;
   logic [3:0]  ovf_o;
   logic [3:0]  done_o;

   int checks = 0;
   int errors = 0;

   gnrc_frac_counter_bank #(.N(16), .CH(4)) dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_ch_i    (cfg_ch_i),
      .cfg_max_i   (cfg_max_i),
      .cfg_inc_i   (cfg_inc_i),
      .cfg_mode_i  (cfg_mode_i),
      .cfg_imm_i   (cfg_imm_i),
      .cfg_err_o   (cfg_err_o),
      .en_i        (en_i),
      .clr_i       (clr_i),
      .down_i      (down_i),
      .cnt_o       (cnt_o),
      .ovf_o       (ovf_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] get_cnt(input int ch);
      return cnt_o[ch*16 +: 16];
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_cfg(input int ch, input int mx, input int ic, input int md, input bit imm);
      cfg_valid_i = 1'b1;
      cfg_ch_i    = 2'(ch);
      cfg_max_i   = 16'(mx);
      cfg_inc_i   = 16'(ic);
      cfg_mode_i  = 2'(md);
      cfg_imm_i   = imm;
      tick();
      cfg_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      arst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if (cnt_o !== 64'd0 || ovf_o !== 4'd0 || done_o !== 4'd0 || cfg_err_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_in: cnt=%h ovf=%b done=%b err=%b rdy=%b want 0/0/0/0/1", cnt_o, ovf_o, done_o, cfg_err_o, cfg_ready_o);
      end
      #2 arst_i = 1'b0;
      en_i = 4'hF;
      tick();
      tick();
      checks++;
      if (cnt_o !== 64'd0 || ovf_o !== 4'd0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: cnt=%h ovf=%b rdy=%b want 0/0/1", cnt_o, ovf_o, cfg_ready_o);
      end
      en_i = 4'h0;
   endtask

   task automatic test_up();
      logic [15:0] exp_cnt [18];
      exp_cnt = '{3, 6, 9, 12, 15, 18, 21, 24, 1, 4, 7, 10, 13, 16, 19, 22, 25, 2};
      send_cfg(0, 26, 3, 0, 1'b1);
      checks++;
      if (cfg_err_o !== 1'b0 || get_cnt(0) !== 16'd0) begin
         errors++;
         $display("FAIL up_cfg: err=%b cnt=%0d want 0/0", cfg_err_o, get_cnt(0));
      end
      en_i[0] = 1'b1;
      for (int k = 0; k < 18; k++) begin
         tick();
         checks++;
         if (get_cnt(0) !== exp_cnt[k] || ovf_o[0] !== ((k == 8) || (k == 17))) begin
            errors++;
            $display("FAIL up_step %0d: cnt=%0d ovf=%b want %0d/%b", k, get_cnt(0), ovf_o[0],
                     exp_cnt[k], ((k == 8) || (k == 17)));
         end
      end
      en_i[0] = 1'b0;
   endtask

   task automatic test_deferred();
      logic [15:0] exp_cnt [8];
      exp_cnt = '{15, 18, 21, 24, 1, 6, 11, 0};
      // clr beats en on the same cycle
      en_i[0]  = 1'b1;
      clr_i[0] = 1'b1;
      tick();
      checks++;
      if (get_cnt(0) !== 16'd0 || ovf_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL clr_beats_en: cnt=%0d ovf=%b want 0/0", get_cnt(0), ovf_o[0]);
      end
      clr_i[0] = 1'b0;
      repeat (3) tick();
      send_cfg(0, 16, 5, 0, 1'b0);
      checks++;
      if (get_cnt(0) !== 16'd12 || cfg_ready_o !== 1'b0 || cfg_err_o !== 1'b0) begin
         errors++;
         $display("FAIL defer_send: cnt=%0d rdy=%b err=%b want 12/0/0", get_cnt(0), cfg_ready_o, cfg_err_o);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (get_cnt(0) !== exp_cnt[k] || ovf_o[0] !== ((k == 4) || (k == 7)) || cfg_ready_o !== (k >= 4)) begin
            errors++;
            $display("FAIL defer_step %0d: cnt=%0d ovf=%b rdy=%b want %0d/%b/%b", k, get_cnt(0), ovf_o[0],
                     cfg_ready_o, exp_cnt[k], ((k == 4) || (k == 7)), (k >= 4));
         end
      end
      en_i[0] = 1'b0;
   endtask

   task automatic test_down();
      logic [15:0] exp_cnt [4];
      exp_cnt = '{23, 20, 17, 14};
      send_cfg(1, 26, 3, 0, 1'b1);
      down_i[1] = 1'b1;
      en_i[1]   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (get_cnt(1) !== exp_cnt[k] || ovf_o[1] !== (k == 0)) begin
            errors++;
            $display("FAIL down_step %0d: cnt=%0d ovf=%b want %0d/%b", k, get_cnt(1), ovf_o[1], exp_cnt[k], (k == 0));
         end
      end
      en_i[1] = 1'b0;
   endtask

   task automatic test_oneshot();
      logic [15:0] exp_cnt [5];
      exp_cnt = '{4, 8, 2, 2, 2};
      send_cfg(2, 10, 4, 1, 1'b1);
      en_i[2] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (get_cnt(2) !== exp_cnt[k] || ovf_o[2] !== (k == 2) || done_o[2] !== (k >= 2)) begin
            errors++;
            $display("FAIL oneshot_step %0d: cnt=%0d ovf=%b done=%b want %0d/%b/%b", k, get_cnt(2), ovf_o[2],
                     done_o[2], exp_cnt[k], (k == 2), (k >= 2));
         end
      end
      clr_i[2] = 1'b1;
      tick();
      checks++;
      if (get_cnt(2) !== 16'd0 || done_o[2] !== 1'b0 || ovf_o[2] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_clr: cnt=%0d done=%b ovf=%b want 0/0/0", get_cnt(2), done_o[2], ovf_o[2]);
      end
      clr_i[2] = 1'b0;
      tick();
      checks++;
      if (get_cnt(2) !== 16'd4 || done_o[2] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_resume: cnt=%0d done=%b want 4/0", get_cnt(2), done_o[2]);
      end
      en_i[2] = 1'b0;
   endtask

   task automatic test_reject();
      send_cfg(3, 20, 7, 0, 1'b1);
      en_i[3] = 1'b1;
      tick();
      en_i[3] = 1'b0;
      checks++;
      if (get_cnt(3) !== 16'd7 || cfg_err_o !== 1'b0) begin
         errors++;
         $display("FAIL rej_setup: cnt=%0d err=%b want 7/0", get_cnt(3), cfg_err_o);
      end
      send_cfg(3, 10, 10, 0, 1'b1);
      checks++;
      if (cfg_err_o !== 1'b1 || get_cnt(3) !== 16'd7) begin
         errors++;
         $display("FAIL rej_inc_ge_max: err=%b cnt=%0d want 1/7", cfg_err_o, get_cnt(3));
      end
      tick();
      checks++;
      if (cfg_err_o !== 1'b0) begin
         errors++;
         $display("FAIL rej_pulse_width: err=%b want 0", cfg_err_o);
      end
      send_cfg(3, 0, 0, 0, 1'b1);
      checks++;
      if (cfg_err_o !== 1'b1) begin
         errors++;
         $display("FAIL rej_max0: err=%b want 1", cfg_err_o);
      end
      send_cfg(3, 20, 3, 2, 1'b1);
      checks++;
      if (cfg_err_o !== 1'b1) begin
         errors++;
         $display("FAIL rej_mode: err=%b want 1", cfg_err_o);
      end
      en_i[3] = 1'b1;
      tick();
      checks++;
      if (get_cnt(3) !== 16'd14 || cfg_err_o !== 1'b0) begin
         errors++;
         $display("FAIL rej_keep1: cnt=%0d err=%b want 14/0", get_cnt(3), cfg_err_o);
      end
      tick();
      checks++;
      if (get_cnt(3) !== 16'd1 || ovf_o[3] !== 1'b1) begin
         errors++;
         $display("FAIL rej_keep2: cnt=%0d ovf=%b want 1/1", get_cnt(3), ovf_o[3]);
      end
      en_i[3] = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_cnt [3];
      exp_cnt = '{6, 1, 12};
      // commit together with clr: new params and cnt=0
      clr_i[3] = 1'b1;
      send_cfg(3, 16, 5, 0, 1'b1);
      clr_i[3] = 1'b0;
      checks++;
      if (get_cnt(3) !== 16'd0 || ovf_o[3] !== 1'b0) begin
         errors++;
         $display("FAIL commit_clr: cnt=%0d ovf=%b want 0/0", get_cnt(3), ovf_o[3]);
      end
      en_i[3] = 1'b1;
      tick();
      en_i[3] = 1'b0;
      checks++;
      if (get_cnt(3) !== 16'd5) begin
         errors++;
         $display("FAIL commit_clr_step: cnt=%0d want 5", get_cnt(3));
      end
      // commit together with a step: the step uses old params (26/3)
      en_i[1] = 1'b1;
      send_cfg(1, 16, 5, 0, 1'b1);
      checks++;
      if (get_cnt(1) !== 16'd11) begin
         errors++;
         $display("FAIL commit_step: cnt=%0d want 11", get_cnt(1));
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (get_cnt(1) !== exp_cnt[k] || ovf_o[1] !== (k == 2)) begin
            errors++;
            $display("FAIL commit_step_after %0d: cnt=%0d ovf=%b want %0d/%b", k, get_cnt(1), ovf_o[1],
                     exp_cnt[k], (k == 2));
         end
      end
      en_i[1]   = 1'b0;
      down_i[1] = 1'b0;
   endtask

   task automatic test_arst();
      send_cfg(0, 26, 3, 0, 1'b0);
      checks++;
      if (cfg_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL arst_pend_setup: rdy=%b want 0", cfg_ready_o);
      end
      en_i = 4'hF;
      repeat (2) tick();
      #2 arst_i = 1'b1;
      #1;
      checks++;
      if (cnt_o !== 64'd0 || ovf_o !== 4'd0 || done_o !== 4'd0 || cfg_err_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL arst_async: cnt=%h ovf=%b done=%b err=%b rdy=%b want 0/0/0/0/1", cnt_o, ovf_o, done_o,
                  cfg_err_o, cfg_ready_o);
      end
      tick();
      #2 arst_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (cnt_o !== 64'd0 || ovf_o !== 4'd0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_idle %0d: cnt=%h ovf=%b rdy=%b want 0/0/1", k, cnt_o, ovf_o, cfg_ready_o);
         end
      end
      send_cfg(0, 26, 3, 0, 1'b1);
      tick();
      checks++;
      if (get_cnt(0) !== 16'd3 || get_cnt(1) !== 16'd0) begin
         errors++;
         $display("FAIL arst_reconfig: cnt0=%0d cnt1=%0d want 3/0", get_cnt(0), get_cnt(1));
      end
      en_i = 4'h0;
   endtask

   initial begin
      cfg_valid_i = 1'b0;
      cfg_ch_i    = 2'd0;
      cfg_max_i   = 16'd0;
      cfg_inc_i   = 16'd0;
      cfg_mode_i  = 2'd0;
      cfg_imm_i   = 1'b0;
      en_i        = 4'h0;
      clr_i       = 4'h0;
      down_i      = 4'h0;
      test_reset();
      test_up();
      test_deferred();
      test_down();
      test_oneshot();
      test_reject();
      test_back_to_back();
      test_arst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
